freq_gate_ctrl: RTL and testbench
=================================

# freq_gate_ctrl

Measurement sequencer that drives the BCD edge counter's `counter_en` (gate) and `clear` inputs and reads back its eight BCD digits and overflow flag. It is the controlling end of the counter interface. It performs a clear handshake against the counter's `ext_signal`-clocked domain, opens a gate of exact length in `clk_50M` cycles, waits for the count to settle, and latches a stable result for the display/UART path. It supports single-shot and continuous measurement.

## Interface
- `GATE_CYCLES`, 50_000_000: gate length in `clk_50M` cycles (1 s); legal range 1..2^32-1.
- `SETTLE_CYCLES`, 8: wait after gate close before latching; minimum 4.
- `CLR_TIMEOUT`, 50_000_000: maximum cycles spent in CLEAR waiting for `ext_signal` edges.
- `clk_50M` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `ext_signal` in 1: raw measured signal; used only for the clear handshake.
- `start` in 1: single-cycle or level request; sampled only in IDLE.
- `cont` in 1: continuous mode; sampled in LATCH.
- `cnt_bcd` in 32: counter digits; digit1 (units) is [3:0], digit8 is [31:28].
- `cnt_over` in 1: counter overflow flag.
- `counter_en` out 1: gate to the counter.
- `clear` out 1: clear to the counter.
- `res_bcd` out 32: latched result, same digit order as `cnt_bcd`.
- `res_over` out 1: latched overflow.
- `res_valid` out 1: one-cycle pulse when `res_bcd`/`res_over`/`no_signal` update.
- `no_signal` out 1: latched; 1 if the last measurement timed out in CLEAR.
- `busy` out 1: high in every state except IDLE.

## Operation
- `ext_signal` passes through a 2-FF synchronizer with rising-edge detect, giving `edge_p`.
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH.
- **IDLE**
  - `clear`=0, `counter_en`=0.
  - `start`=1 moves to CLEAR.
- **CLEAR**
  - `clear`=1.
  - Counts `edge_p`. After the 2nd edge, moves to GATE. Two edges guarantee that the counter sampled `clear`=1 on at least one of its own posedges despite synchronizer lag.
  - If the timer reaches CLR_TIMEOUT first, sets an internal timeout flag and moves to LATCH, skipping GATE and SETTLE.
- **GATE**
  - `clear`=0, `counter_en`=1.
  - Lasts exactly GATE_CYCLES cycles, then moves to SETTLE.
- **SETTLE**
  - `counter_en`=0.
  - Lasts SETTLE_CYCLES cycles, covering the counter's last in-flight `ext_signal` edge plus the cross-domain settling of `cnt_bcd`.
  - Then moves to LATCH.
- **LATCH** (one cycle)
  - Normal path: captures `cnt_bcd`→`res_bcd`, `cnt_over`→`res_over`, and sets `no_signal`=0.
  - Timeout path: `res_bcd`=0, `res_over`=0, `no_signal`=1.
  - Next state is CLEAR if `cont`=1, otherwise IDLE.
- One shared 32-bit down-counter serves as the timer for CLEAR, GATE and SETTLE. It is reloaded on every state entry and never wraps.
- `start` is ignored while `busy`=1. In IDLE, a `start` held high simply begins the next measurement.
- `cont` dropping mid-measurement takes effect at the next LATCH; the current measurement completes.

## Timing
- All outputs are registered. Reset values:
  - `counter_en`=0, `clear`=0, `res_bcd`=0, `res_over`=0, `res_valid`=0, `no_signal`=0, `busy`=0; state = IDLE.
- `start` high in IDLE at cycle t gives `clear`=1 and `busy`=1 at t+1.
- `counter_en` is high for exactly GATE_CYCLES consecutive cycles per measurement. `clear` and `counter_en` are never high in the same cycle.
- `res_valid` pulses for 1 cycle, in the cycle after LATCH, with the new `res_*` values visible in that same cycle.
- In continuous mode, `clear` re-asserts in that same cycle. There is no IDLE gap.
- Edge-detect latency: an `ext_signal` rise is seen as `edge_p` 2–3 cycles later.
- Reset mid-operation (any state): the next cycle is IDLE, with `counter_en`=0, `clear`=0, and all result outputs at their reset values.
- `rst` and `start` in the same cycle: reset wins.

## Structure
- Package `freq_meter_pkg`:
  - state enum;
  - `DIGITS`=8, `BCD_W`=4, `RES_W`=`DIGITS*BCD_W`;
  - `TMR_W`=32;
  - `CLR_EDGES`=2.
- Sub-module `edge_sync`: 2-FF synchronizer plus rising-edge pulse. It has its own `clk_50M`/`rst` and is reused by other async inputs in the design.
- FSM, timer and result registers all live in `freq_gate_ctrl`.

## Test plan
Bench uses GATE_CYCLES=100, SETTLE_CYCLES=4, CLR_TIMEOUT=50, and a behavioral model of the BCD counter clocked by `ext_signal`.
- **Single shot:** `ext_signal` period 10 cycles, `start` pulse → `counter_en` high exactly 100 cycles; one `res_valid`; `res_bcd`=10 (±1, gate phase); `res_over`=0; `busy` back to 0.
- **No signal:** `ext_signal` held at 0, `start` → `clear` high 50 cycles; `counter_en` never asserts; `res_valid` with `no_signal`=1 and `res_bcd`=0.
- **Continuous:** `cont`=1, `ext_signal` period 4 → back-to-back `res_valid` pulses, each showing 25±1; `clear`=1 in each `res_valid` cycle. Then `cont`=0 → exactly one more result, then IDLE.
- **Overflow:** model counter preloaded to 99999999 → `res_over`=1 and `res_bcd` wraps to a small count.
- **Reset mid-GATE:** `rst` pulse at gate cycle 50 → next cycle `counter_en`=0, `busy`=0, `res_bcd`=0, no `res_valid` pulse.
- **Busy lockout:** `start` pulses during CLEAR and GATE → exactly one measurement and one `res_valid`.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: sequencer states,
// result geometry and timer width.
package freq_meter_pkg;

   localparam int DIGITS    = 8;
   localparam int BCD_W     = 4;
   localparam int RES_W     = DIGITS * BCD_W;
   localparam int TMR_W     = 32;
   localparam int CLR_EDGES = 2;
   localparam int EDGE_W    = $clog2(CLR_EDGES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GATE,
      ST_SETTLE,
      ST_LATCH
   } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input with a single-cycle
// rising-edge pulse on the synchronized level.
module edge_sync (
   input  logic clk_50M,
   input  logic rst,
   input  logic async_in,
   output logic edge_p
);

   // [0],[1] form the synchronizer; [2] is the previous synchronized level.
   logic [2:0] sync_q;

   // Shift the raw input through the synchronizer and keep one delayed copy.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking, so each stage samples its neighbour's pre-edge value.
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign edge_p = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the BCD edge counter: clear handshake against the
// measured signal, exact-length gate, settle wait, then a one-cycle latch of
// the counter digits into stable result registers. Single-shot or continuous.
module freq_gate_ctrl
   import freq_meter_pkg::*;
#(
   parameter logic [TMR_W-1:0] GATE_CYCLES   = 32'd50_000_000,
   parameter logic [TMR_W-1:0] SETTLE_CYCLES = 32'd8,
   parameter logic [TMR_W-1:0] CLR_TIMEOUT   = 32'd50_000_000
) (
   input  logic             clk_50M,
   input  logic             rst,
   input  logic             ext_signal,
   input  logic             start,
   input  logic             cont,
   input  logic [RES_W-1:0] cnt_bcd,
   input  logic             cnt_over,
   output logic             counter_en,
   output logic             clear,
   output logic [RES_W-1:0] res_bcd,
   output logic             res_over,
   output logic             res_valid,
   output logic             no_signal,
   output logic             busy
);

   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(CLR_EDGES - 1);

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic                timeout_q, timeout_d;
   logic                timer_last;
   logic                edge_p;

   // Value loaded into the shared timer when a state is entered.
   function automatic logic [TMR_W-1:0] entry_load(input state_t s);
      case (s)
         ST_CLEAR:  return CLR_TIMEOUT;
         ST_GATE:   return GATE_CYCLES;
         ST_SETTLE: return SETTLE_CYCLES;
         default:   return '0;
      endcase
   endfunction

   edge_sync u_edge_sync (
      .clk_50M  (clk_50M),
      .rst      (rst),
      .async_in (ext_signal),
      .edge_p   (edge_p)
   );

   // The current state ends in this cycle; <= also covers a zero load.
   assign timer_last = (timer_q <= TMR_ONE);

   // Next-state, timer reload/decrement, clear-edge count and timeout flag.
   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d    = state_q;
      edge_cnt_d = edge_cnt_q;
      timeout_d  = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (edge_p && (edge_cnt_q == EDGE_LAST)) begin
               state_d = ST_GATE;
            end else begin
               if (edge_p) edge_cnt_d = edge_cnt_q + EDGE_W'(1);
               if (timer_last) begin
                  state_d   = ST_LATCH;
                  timeout_d = 1'b1;
               end
            end
         end
         ST_GATE: begin
            if (timer_last) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (timer_last) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            state_d = cont ? ST_CLEAR : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Every state entry reloads the timer; otherwise it counts down and
      // parks at zero rather than wrapping.
      if (state_d != state_q) begin
         timer_d = entry_load(state_d);
      end else if (timer_q != '0) begin
         timer_d = timer_q - TMR_ONE;
      end else begin
         timer_d = timer_q;
      end

      // A fresh handshake starts with no edges seen and no timeout.
      if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
         edge_cnt_d = '0;
         timeout_d  = 1'b0;
      end
   end

   // State, timer and registered outputs; results update only out of LATCH.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         edge_cnt_q <= '0;
         timeout_q  <= 1'b0;
         counter_en <= 1'b0;
         clear      <= 1'b0;
         busy       <= 1'b0;
         res_bcd    <= '0;
         res_over   <= 1'b0;
         res_valid  <= 1'b0;
         no_signal  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         edge_cnt_q <= edge_cnt_d;
         timeout_q  <= timeout_d;
         // Decoded from the next state so each output lines up with its state.
         counter_en <= (state_d == ST_GATE);
         clear      <= (state_d == ST_CLEAR);
         busy       <= (state_d != ST_IDLE);
         res_valid  <= (state_q == ST_LATCH);
         if (state_q == ST_LATCH) begin
            res_bcd   <= timeout_q ? '0 : cnt_bcd;
            res_over  <= timeout_q ? 1'b0 : cnt_over;
            no_signal <= timeout_q;
         end
      end
   end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: a behavioural BCD counter clocked by
// ext_signal, expected results queued at stimulus time and a monitor that
// compares whenever res_valid pulses.
module tb_freq_gate_ctrl;

   localparam int  GATE   = 100;
   localparam int  SETTLE = 4;
   localparam int  CLR_TO = 50;
   localparam longint WRAP = 100000000;

   logic        clk_50M;
   logic        rst;
   logic        ext_signal;
   logic        start;
   logic        cont;
   logic [31:0] cnt_bcd;
   logic        cnt_over;
   logic        counter_en;
   logic        clear;
   logic [31:0] res_bcd;
   logic        res_over;
   logic        res_valid;
   logic        no_signal;
   logic        busy;

   typedef struct {
      longint lo;
      longint hi;
      bit     over;
      bit     nosig;
      bit     clr;
   } exp_t;

   exp_t   sb[$];
   int     gate_runs[$];
   int     clear_runs[$];
   int     gate_len   = 0;
   int     clear_len  = 0;
   int     overlap    = 0;
   int     n_results  = 0;
   bit     prev_valid = 0;
   int     ext_half   = 0;
   longint cnt_val    = 0;
   longint clear_value = 0;
   int     total = 0;
   int     bad   = 0;

   freq_gate_ctrl #(
      .GATE_CYCLES   (32'(GATE)),
      .SETTLE_CYCLES (32'(SETTLE)),
      .CLR_TIMEOUT   (32'(CLR_TO))
   ) dut (
      .clk_50M    (clk_50M),
      .rst        (rst),
      .ext_signal (ext_signal),
      .start      (start),
      .cont       (cont),
      .cnt_bcd    (cnt_bcd),
      .cnt_over   (cnt_over),
      .counter_en (counter_en),
      .clear      (clear),
      .res_bcd    (res_bcd),
      .res_over   (res_over),
      .res_valid  (res_valid),
      .no_signal  (no_signal),
      .busy       (busy)
   );

   // 100 MHz-style bench clock: posedges at 5, 15, 25 ...
   initial begin
      clk_50M = 1'b0;
      forever #5 clk_50M = ~clk_50M;
   end

   // Measured signal: toggles at times = 2 mod 10, never on a clock edge.
   initial begin
      ext_signal = 1'b0;
      #2;
      forever begin
         if (ext_half == 0) begin
            ext_signal = 1'b0;
            #10;
         end else begin
            ext_signal = ~ext_signal;
            #(ext_half);
         end
      end
   end

   function automatic logic [31:0] int_to_bcd(input longint v);
      logic [31:0] r;
      longint      t;
      t = v;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic longint bcd_to_int(input logic [31:0] b);
      longint v;
      v = 0;
      for (int i = 7; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
      return v;
   endfunction

   // Behavioural BCD counter living in the ext_signal domain.
   initial cnt_over = 1'b0;
   always @(posedge ext_signal) begin
      if (clear) begin
         cnt_val  <= clear_value;
         cnt_over <= 1'b0;
      end else if (counter_en) begin
         if (cnt_val + 1 >= WRAP) begin
            cnt_val  <= 0;
            cnt_over <= 1'b1;
         end else begin
            cnt_val <= cnt_val + 1;
         end
      end
   end
   assign cnt_bcd = int_to_bcd(cnt_val);

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act,
                              input longint lo, input longint hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Expected result: the gate spans GATE/period signal periods, +-1 for phase.
   task automatic push_exp(input int period, input bit clr);
      exp_t   e;
      longint full;
      full    = clear_value + longint'(GATE / period);
      e.lo    = (full - 1) % WRAP;
      e.hi    = (full + 1) % WRAP;
      e.over  = (full >= WRAP);
      e.nosig = 1'b0;
      e.clr   = clr;
      sb.push_back(e);
   endtask

   task automatic push_nosig();
      exp_t e;
      e.lo    = 0;
      e.hi    = 0;
      e.over  = 1'b0;
      e.nosig = 1'b1;
      e.clr   = 1'b0;
      sb.push_back(e);
   endtask

   // sel: 0 busy low, 1 counter_en high, 2 clear high, 3 n_results >= arg.
   task automatic wait_for(input string what, input int sel, input int arg, input int budget);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < budget) begin
         @(negedge clk_50M);
         case (sel)
            0:       ok = !busy;
            1:       ok = counter_en;
            2:       ok = clear;
            default: ok = (n_results >= arg);
         endcase
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL timeout_%s: waited %0d cycles, required condition never met", what, budget);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_50M);
      start = 1'b0;
   endtask

   // Monitor: run lengths, overlap, and scoreboard pop on every result pulse.
   always @(negedge clk_50M) begin
      exp_t e;
      if (clear && counter_en) overlap++;
      if (counter_en) gate_len++;
      else if (gate_len != 0) begin
         gate_runs.push_back(gate_len);
         gate_len = 0;
      end
      if (clear) clear_len++;
      else if (clear_len != 0) begin
         clear_runs.push_back(clear_len);
         clear_len = 0;
      end
      if (res_valid) begin
         n_results++;
         check("res_valid_width", prev_valid, 0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got res_valid with res_bcd=%h, required no result", res_bcd);
         end else begin
            e = sb.pop_front();
            check_range("res_bcd", bcd_to_int(res_bcd), e.lo, e.hi);
            check("res_over", res_over, e.over);
            check("no_signal", no_signal, e.nosig);
            check("clear_at_valid", clear, e.clr);
            check("busy_at_valid", busy, e.clr);
         end
      end
      prev_valid = res_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst   = 1'b1;
      start = 1'b0;
      cont  = 1'b0;
      repeat (3) @(negedge clk_50M);
      check("rst_counter_en", counter_en, 0);
      check("rst_clear", clear, 0);
      check("rst_res_bcd", res_bcd, 0);
      check("rst_res_over", res_over, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_no_signal", no_signal, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // Single shot, period 10.
      ext_half = 50;
      repeat (30) @(negedge clk_50M);
      gate_runs.delete();
      base = n_results;
      push_exp(10, 1'b0);
      pulse_start();
      check("start_clear_t1", clear, 1);
      check("start_busy_t1", busy, 1);
      wait_for("single_result", 3, base + 1, 500);
      @(negedge clk_50M);
      check("single_busy_after", busy, 0);
      check("single_gate_runs", gate_runs.size(), 1);
      if (gate_runs.size() > 0) check("single_gate_len", gate_runs[0], GATE);

      // No signal: clear handshake times out.
      ext_half = 0;
      repeat (20) @(negedge clk_50M);
      gate_runs.delete();
      clear_runs.delete();
      base = n_results;
      push_nosig();
      pulse_start();
      wait_for("nosig_result", 3, base + 1, 300);
      repeat (5) @(negedge clk_50M);
      check("nosig_gate_runs", gate_runs.size(), 0);
      check("nosig_clear_runs", clear_runs.size(), 1);
      if (clear_runs.size() > 0) check("nosig_clear_len", clear_runs[0], CLR_TO);
      check("nosig_busy_after", busy, 0);

      // Continuous, period 4, then drop cont for exactly one more result.
      ext_half = 20;
      repeat (20) @(negedge clk_50M);
      gate_runs.delete();
      base = n_results;
      cont = 1'b1;
      push_exp(4, 1'b1);
      push_exp(4, 1'b1);
      push_exp(4, 1'b0);
      pulse_start();
      wait_for("cont_two", 3, base + 2, 1000);
      cont = 1'b0;
      wait_for("cont_three", 3, base + 3, 500);
      wait_for("cont_idle", 0, 0, 50);
      repeat (150) @(negedge clk_50M);
      check("cont_result_count", n_results - base, 3);
      check("cont_gate_runs", gate_runs.size(), 3);
      check("cont_sb_empty", sb.size(), 0);

      // Overflow: counter clears to 99999999 so the gate wraps it.
      ext_half = 50;
      clear_value = WRAP - 1;
      repeat (20) @(negedge clk_50M);
      base = n_results;
      push_exp(10, 1'b0);
      pulse_start();
      wait_for("over_result", 3, base + 1, 500);
      clear_value = 0;
      @(negedge clk_50M);

      // Reset at gate cycle 50.
      gate_runs.delete();
      base = n_results;
      pulse_start();
      wait_for("rst_gate_open", 1, 0, 200);
      repeat (49) @(negedge clk_50M);
      rst = 1'b1;
      @(negedge clk_50M);
      check("midrst_counter_en", counter_en, 0);
      check("midrst_clear", clear, 0);
      check("midrst_busy", busy, 0);
      check("midrst_res_bcd", res_bcd, 0);
      check("midrst_res_over", res_over, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_no_signal", no_signal, 0);
      rst = 1'b0;
      repeat (200) @(negedge clk_50M);
      check("midrst_no_result", n_results - base, 0);
      check("midrst_gate_len", gate_runs.size() > 0 ? gate_runs[0] : 0, 50);

      // Busy lockout: extra start pulses in CLEAR and GATE are ignored.
      gate_runs.delete();
      base = n_results;
      push_exp(10, 1'b0);
      pulse_start();
      wait_for("lock_clear", 2, 0, 20);
      pulse_start();
      wait_for("lock_gate", 1, 0, 200);
      repeat (20) @(negedge clk_50M);
      pulse_start();
      wait_for("lock_idle", 0, 0, 300);
      repeat (150) @(negedge clk_50M);
      check("lock_result_count", n_results - base, 1);
      check("lock_gate_runs", gate_runs.size(), 1);
      check("lock_busy", busy, 0);

      // Reset and start in the same cycle: reset wins.
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk_50M);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_clear", clear, 0);
      repeat (5) @(negedge clk_50M);
      check("rst_start_idle", busy, 0);

      check("clear_gate_overlap", overlap, 0);
      check("sb_empty_end", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
